// File: rtl/regfile_wr_arbiter_if.sv
// Writeback bus between the two writeback sources, the arbiter and the register file write port.
// The master modport is the requester/register-file side and the slave modport is the arbiter.
interface regfile_wr_arbiter_if #(
    parameter int WIDTH   = 8,
    parameter int REGBITS = 3,
    parameter int CNTW    = 8
);
    logic                    req0_valid;
    logic [REGBITS-1:0]      req0_addr;
    logic [WIDTH-1:0]        req0_data;
    logic                    req0_ready;
    logic                    req1_valid;
    logic [REGBITS-1:0]      req1_addr;
    logic [WIDTH-1:0]        req1_data;
    logic                    req1_ready;
    logic                    wb_hold;
    logic                    regwrite;
    logic [REGBITS-1:0]      wa;
    logic [WIDTH-1:0]        wd;
    logic [(2**REGBITS)-1:0] pend_mask;
    logic [CNTW-1:0]         conflict_cnt;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        output wb_hold,
        input  req0_ready, req1_ready,
        input  regwrite, wa, wd, pend_mask, conflict_cnt
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        input  wb_hold,
        output req0_ready, req1_ready,
        output regwrite, wa, wd, pend_mask, conflict_cnt
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Two-source register file write-port arbiter (ALU vs load) with registered write, pending mask and
// saturating conflict counter. Define REGFILE_ARB_FIXED_PRIO_EN to make the load source always win.
module regfile_wr_arbiter #(
    parameter int WIDTH   = 8,
    parameter int REGBITS = 3,
    parameter int CNTW    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    regfile_wr_arbiter_if.slave    bus
);
    localparam int NREGS = 2**REGBITS;

    logic               w_both;
    logic               w_live;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_gnt;
    logic               w_contest;
    logic               w_wr_en;
    logic [REGBITS-1:0] w_gnt_addr;
    logic [WIDTH-1:0]   w_gnt_data;
    logic [NREGS-1:0]   w_onehot;

    logic               r_regwrite;
    logic [REGBITS-1:0] r_wa;
    logic [WIDTH-1:0]   r_wd;
    logic [NREGS-1:0]   r_pend_mask;
    logic [CNTW-1:0]    r_conflict_cnt;

    // NOTE: rst_n gates the grants directly so ready is 0 during reset without waiting for a clock.
    assign w_live    = rst_n & ~bus.wb_hold;
    assign w_both    = bus.req0_valid & bus.req1_valid;
    assign w_contest = w_live & w_both;

`ifdef REGFILE_ARB_FIXED_PRIO_EN
    assign w_gnt1 = w_live & bus.req1_valid;
    assign w_gnt0 = w_live & bus.req0_valid & ~bus.req1_valid;
`else
    logic r_rr_ptr;

    assign w_gnt0 = w_live & bus.req0_valid & (~bus.req1_valid | ~r_rr_ptr);
    assign w_gnt1 = w_live & bus.req1_valid & (~bus.req0_valid |  r_rr_ptr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= 1'b0;
        end else if (w_contest) begin
            r_rr_ptr <= ~r_rr_ptr;
        end
    end
`endif

    assign w_gnt      = w_gnt0 | w_gnt1;
    assign w_gnt_addr = w_gnt1 ? bus.req1_addr : bus.req0_addr;
    assign w_gnt_data = w_gnt1 ? bus.req1_data : bus.req0_data;
    // Writes to register 0 are accepted from the requester but never reach the register file.
    assign w_wr_en    = w_gnt & (w_gnt_addr != '0);
    assign w_onehot   = NREGS'(1) << w_gnt_addr;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regwrite     <= 1'b0;
            r_wa           <= '0;
            r_wd           <= '0;
            r_pend_mask    <= '0;
            r_conflict_cnt <= '0;
        end else begin
            r_regwrite  <= w_wr_en;
            r_pend_mask <= w_wr_en ? w_onehot : '0;
            if (w_gnt) begin
                r_wa <= w_gnt_addr;
                r_wd <= w_gnt_data;
            end
            if (w_contest && (r_conflict_cnt != '1)) begin
                r_conflict_cnt <= r_conflict_cnt + CNTW'(1);
            end
        end
    end

    assign bus.req0_ready   = w_gnt0;
    assign bus.req1_ready   = w_gnt1;
    assign bus.regwrite     = r_regwrite;
    assign bus.wa           = r_wa;
    assign bus.wd           = r_wd;
    assign bus.pend_mask    = r_pend_mask;
    assign bus.conflict_cnt = r_conflict_cnt;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: a cycle model predicts grants and pushes expected writes,
// a separate monitor pops them whenever the register file port is sampled.
module tb_regfile_wr_arbiter;
    localparam int WIDTH   = 8;
    localparam int REGBITS = 3;
    localparam int CNTW    = 8;
    localparam int CMAX    = (1 << CNTW) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    regfile_wr_arbiter_if #(.WIDTH(WIDTH), .REGBITS(REGBITS), .CNTW(CNTW)) bus ();

    regfile_wr_arbiter #(.WIDTH(WIDTH), .REGBITS(REGBITS), .CNTW(CNTW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int                 cyc;
        logic [REGBITS-1:0] a;
        logic [WIDTH-1:0]   d;
    } wr_t;

    wr_t exp_q[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    int  n_contest = 0;
    int  m_cnt = 0;
    int  g0 = 0;
    int  g1 = 0;
    bit  acc0, acc1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: contested grants alternate starting with requester 0, so the winner of the
    // n-th contest is n mod 2; with fixed priority the load source always wins.
    task automatic model_cycle();
        bit v0, v1, live, win1, e0, e1;
        v0   = bus.req0_valid;
        v1   = bus.req1_valid;
        live = rst_n && !bus.wb_hold;
`ifdef REGFILE_ARB_FIXED_PRIO_EN
        win1 = 1'b1;
`else
        win1 = (n_contest % 2) == 1;
`endif
        e0 = live && v0 && (!v1 || !win1);
        e1 = live && v1 && (!v0 || win1);
        check("conflict_cnt", bus.conflict_cnt, m_cnt);
        check("req0_ready", bus.req0_ready, e0);
        check("req1_ready", bus.req1_ready, e1);
        acc0 = v0 && bus.req0_ready;
        acc1 = v1 && bus.req1_ready;
        if (acc0) g0++;
        if (acc1) g1++;
        if (e0 && bus.req0_addr != 0) exp_q.push_back('{cyc + 1, bus.req0_addr, bus.req0_data});
        if (e1 && bus.req1_addr != 0) exp_q.push_back('{cyc + 1, bus.req1_addr, bus.req1_data});
        if (live && v0 && v1) begin
            n_contest++;
            if (m_cnt < CMAX) m_cnt++;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            begin
                wr_t e;
                bit  due;
                due = (exp_q.size() != 0) && (exp_q[0].cyc == cyc);
                check("regwrite", bus.regwrite, due);
                if (due) begin
                    e = exp_q.pop_front();
                    check("wa", bus.wa, e.a);
                    check("wd", bus.wd, e.d);
                    check("pend_mask", bus.pend_mask, 32'(1) << e.a);
                end else begin
                    check("idle_pend_mask", bus.pend_mask, 0);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        m_cnt     = 0;
        n_contest = 0;
        #2;
        check("rst_regwrite", bus.regwrite, 0);
        check("rst_pend_mask", bus.pend_mask, 0);
        check("rst_conflict_cnt", bus.conflict_cnt, 0);
        step();
        rst_n = 1'b1;
    endtask

    task automatic present0(input logic [REGBITS-1:0] a, input logic [WIDTH-1:0] d);
        bus.req0_valid = 1'b1;
        bus.req0_addr  = a;
        bus.req0_data  = d;
    endtask

    task automatic present1(input logic [REGBITS-1:0] a, input logic [WIDTH-1:0] d);
        bus.req1_valid = 1'b1;
        bus.req1_addr  = a;
        bus.req1_data  = d;
    endtask

    initial begin
        bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
        bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
        bus.wb_hold    = 1'b0;
        #1;
        do_reset();

        // Single ALU write.
        present0(3'd3, 8'h5A);
        step();
        check("t1_ready0", acc0, 1);
        bus.req0_valid = 1'b0;
        check("t1_regwrite", bus.regwrite, 1);
        check("t1_wa", bus.wa, 3);
        check("t1_wd", bus.wd, 8'h5A);
        check("t1_pend_mask", bus.pend_mask, 8'b0000_1000);

        // Contention from reset, both held until accepted.
        do_reset();
        present0(3'd1, 8'h11);
        present1(3'd2, 8'h22);
        for (int k = 0; k < 6 && (bus.req0_valid || bus.req1_valid); k++) begin
            step();
            if (k == 0) begin
`ifdef REGFILE_ARB_FIXED_PRIO_EN
                check("t2_first_winner_req1", acc1, 1);
`else
                check("t2_first_winner_req0", acc0, 1);
`endif
            end
            if (acc0) bus.req0_valid = 1'b0;
            if (acc1) bus.req1_valid = 1'b0;
        end
        check("t2_both_accepted", {bus.req0_valid, bus.req1_valid}, 0);
        check("t2_conflict_cnt", bus.conflict_cnt, 1);
        step();

        // Register 0 target is accepted but never written.
        present1(3'd0, 8'hFF);
        step();
        check("t3_ready1", acc1, 1);
        bus.req1_valid = 1'b0;
        check("t3_regwrite", bus.regwrite, 0);
        check("t3_pend_mask", bus.pend_mask, 0);

        // Hold freezes grants for three cycles.
        present0(3'd5, 8'h33);
        bus.wb_hold = 1'b1;
        repeat (3) begin
            step();
            check("t4_ready0_held", acc0, 0);
            check("t4_regwrite_held", bus.regwrite, 0);
        end
        bus.wb_hold = 1'b0;
        step();
        check("t4_ready0_release", acc0, 1);
        bus.req0_valid = 1'b0;

        // Continuous contention: saturation and fairness.
        do_reset();
        g0 = 0;
        g1 = 0;
        present0(REGBITS'($urandom), WIDTH'($urandom));
        present1(REGBITS'($urandom), WIDTH'($urandom));
        repeat (300) begin
            step();
            if (acc0) present0(REGBITS'($urandom), WIDTH'($urandom));
            if (acc1) present1(REGBITS'($urandom), WIDTH'($urandom));
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        check("t5_conflict_sat", bus.conflict_cnt, 255);
`ifdef REGFILE_ARB_FIXED_PRIO_EN
        check("t5_grants0", g0, 0);
        check("t5_grants1", g1, 300);
`else
        check("t5_grants0", g0, 150);
        check("t5_grants1", g1, 150);
`endif

        // Reset between grant and write drops the write.
        present0(3'd4, 8'h77);
        step();
        bus.req0_valid = 1'b0;
        check("t6_inflight_regwrite", bus.regwrite, 1);
        do_reset();
        check("t6_regwrite_after", bus.regwrite, 0);
        check("t6_conflict_after", bus.conflict_cnt, 0);

        // Randomized traffic with holds.
        for (int i = 0; i < 500; i++) begin
            bus.wb_hold = ($urandom % 6) == 0;
            if (!bus.req0_valid && ($urandom % 3) != 0) present0(REGBITS'($urandom), WIDTH'($urandom));
            if (!bus.req1_valid && ($urandom % 3) != 0) present1(REGBITS'($urandom), WIDTH'($urandom));
            step();
            if (acc0) bus.req0_valid = 1'b0;
            if (acc1) bus.req1_valid = 1'b0;
        end

        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.wb_hold    = 1'b0;
        repeat (3) step();
        check("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
Shares the register file's single write port between two writeback sources: requester 0 (ALU writeback) and requester 1 (memory load writeback). Each requester uses a valid/ready handshake. The block arbitrates, and registers the winning address and data. It then drives the register file's regwrite/wa/wd pins one cycle later. It also provides a pending-write mask for forwarding/hazard logic and a saturating conflict counter for performance debug.

Parameters:
WIDTH, 8, data width of a register
REGBITS, 3, register address width; 2**REGBITS registers
CNTW, 8, width of conflict counter

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
req0_valid  input  1  ALU writeback request
req0_addr  input  REGBITS  ALU destination register
req0_data  input  WIDTH  ALU result
req0_ready  output  1  ALU request accepted this cycle (combinational)
req1_valid  input  1  load writeback request
req1_addr  input  REGBITS  load destination register
req1_data  input  WIDTH  load data
req1_ready  output  1  load request accepted this cycle (combinational)
wb_hold  input  1  freeze: no grants while high
regwrite  output  1  register file write enable (registered)
wa  output  REGBITS  register file write address (registered)
wd  output  WIDTH  register file write data (registered)
pend_mask  output  2**REGBITS  one-hot of register targeted by the current regwrite, else 0
conflict_cnt  output  CNTW  saturating count of cycles in which both valid and one was refused

Behaviour:
- Reset (rst_n low, asynchronous): regwrite=0, wa=0, wd=0, pend_mask=0, conflict_cnt=0, rr_ptr=0. req*_ready are combinational and therefore 0 while inputs are idle.
- Handshake: a transfer occurs when reqN_valid & reqN_ready. reqN_ready=0 whenever wb_hold=1 or rst_n=0. reqN_ready never depends on another cycle's ready. A requester must hold valid/addr/data stable until accepted.
- Arbitration, each cycle with wb_hold=0:
  - Only one valid: grant it.
  - Both valid: grant the requester indicated by rr_ptr. rr_ptr = index of the requester with priority (0 or 1). rr_ptr then flips to the other requester.
  - rr_ptr updates only on a contested grant.
  - At most one grant per cycle.
- Latency: the cycle after a grant, regwrite=1, wa=granted addr, wd=granted data, and pend_mask=(1<<wa). With no grant, regwrite=0 and pend_mask=0. wa/wd hold their last values.
- Register 0: a granted request with addr=0 is accepted (ready=1), but the next cycle forces regwrite=0 and pend_mask=0. $zero is never written.
- conflict_cnt: increments by 1 each cycle with both valid and wb_hold=0. Saturates at all-ones; it does not wrap. Cycles with wb_hold=1 are not counted.
- wb_hold=1 during a cycle: no grant. regwrite deasserts the following cycle. A write already registered completes normally.
- Both requesters targeting the same register in one cycle: only the winner is accepted. The loser writes in a later cycle, so the last write wins in grant order.
- rst_n asserted mid-transfer: an in-flight registered write is dropped (regwrite→0 immediately). Requesters see no acceptance and must re-present.

Optional Feature:
- Macro: REGFILE_ARB_FIXED_PRIO_EN.
- Defined: requester 1 (load) always wins contention. rr_ptr is removed, and req0 waits while req1_valid=1. conflict_cnt behaves the same.
- Undefined: round-robin as described above.

Test Plan:
1. Reset, then req0 valid addr=3 data=8'h5A -> req0_ready=1 same cycle; next cycle regwrite=1, wa=3, wd=8'h5A, pend_mask=8'b0000_1000.
2. Both valid (req0 addr=1 data=8'h11, req1 addr=2 data=8'h22), held until accepted, after reset -> req0 granted in cycle 0, req1 in cycle 1. Writes appear in cycles 1 and 2. conflict_cnt=1.
3. req1 valid addr=0 data=8'hFF -> req1_ready=1; next cycle regwrite=0, pend_mask=0.
4. wb_hold=1 for 3 cycles with req0 valid -> req0_ready=0 throughout; regwrite=0. Grant occurs on the first cycle after hold drops.
5. Both valid continuously for 300 cycles (CNTW=8) -> conflict_cnt saturates at 255. Grants alternate exactly 150/150.
6. rst_n pulsed low between a grant and its write cycle -> regwrite stays 0, conflict_cnt=0. With REGFILE_ARB_FIXED_PRIO_EN defined, rerun test 2 -> req1 is granted first.
